ball_motion: RTL

- Consumer side of the ball timer tick: advances the Breakout ball one step per tick pulse.
- Reflects the ball off the walls, the paddle and bricks, and reports a lost ball.
- Sits between the tick timer and the renderer, brick field and lives/score logic.
- Owns ball position, direction and the serve/play state.

---
 rtl/breakout_pkg.sv | 18 +
 rtl/ball_axis.sv | 39 +++
 rtl/ball_motion.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/breakout_pkg.sv
// Shared Breakout geometry, coordinate width and ball FSM encoding.
package breakout_pkg;

    localparam int COORD_W = 10;

    localparam int SCREEN_W_DEF  = 640;
    localparam int SCREEN_H_DEF  = 480;
    localparam int BALL_SIZE_DEF = 8;
    localparam int PADDLE_W_DEF  = 64;
    localparam int PADDLE_Y_DEF  = 440;
    localparam int STEP_DEF      = 1;

    typedef logic [1:0] ball_state_t;
    localparam ball_state_t ST_SERVE = 2'd0;
    localparam ball_state_t ST_MOVE  = 2'd1;
    localparam ball_state_t ST_LOST  = 2'd2;

endpackage

// File: rtl/ball_axis.sv
// One motion axis: step the position, clamp to [lo, hi] and reflect at either limit.
module ball_axis
    import breakout_pkg::*;
(
    input  logic [COORD_W-1:0]        i_pos,
    input  logic                      i_dir_neg,
    input  logic [COORD_W-1:0]        i_step,
    input  logic [COORD_W-1:0]        i_lo,
    input  logic [COORD_W-1:0]        i_hi,
    output logic signed [COORD_W:0]   o_raw,
    output logic [COORD_W-1:0]        o_pos,
    output logic                      o_dir_neg,
    output logic                      o_hit_lo,
    output logic                      o_hit_hi
);

    logic signed [COORD_W:0] w_pos_s;
    logic signed [COORD_W:0] w_step_s;

    assign w_pos_s  = $signed({1'b0, i_pos});
    assign w_step_s = $signed({1'b0, i_step});
    assign o_raw    = i_dir_neg ? (w_pos_s - w_step_s) : (w_pos_s + w_step_s);

    assign o_hit_lo = (o_raw <= $signed({1'b0, i_lo}));
    assign o_hit_hi = (o_raw >= $signed({1'b0, i_hi}));

    always_comb begin
        o_pos     = o_raw[COORD_W-1:0];
        o_dir_neg = i_dir_neg;
        if (o_hit_lo) begin
            o_pos     = i_lo;
            o_dir_neg = 1'b0;
        end else if (o_hit_hi) begin
            o_pos     = i_hi;
            o_dir_neg = 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Breakout ball motion: serve tracking, per-tick movement, wall/paddle/brick bounces, miss.
// Optional BALL_SPEEDUP_EN doubles the step after 8 paddle hits until the ball is lost.
module ball_motion
    import breakout_pkg::*;
#(
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int SCREEN_H  = SCREEN_H_DEF,
    parameter int BALL_SIZE = BALL_SIZE_DEF,
    parameter int PADDLE_W  = PADDLE_W_DEF,
    parameter int PADDLE_Y  = PADDLE_Y_DEF,
    parameter int STEP      = STEP_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               launch,
    input  logic [COORD_W-1:0] paddle_x,
    input  logic               brick_hit,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               ball_dx_neg,
    output logic               ball_dy_neg,
    output logic               in_play,
    output logic               paddle_hit,
    output logic               ball_lost
);

    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(SCREEN_W - BALL_SIZE);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(SCREEN_H - BALL_SIZE);
    localparam logic [COORD_W-1:0] Y_REST = COORD_W'(PADDLE_Y - BALL_SIZE);
    localparam logic [COORD_W-1:0] ZERO   = '0;

    ball_state_t        r_state, w_state_nxt;
    logic [COORD_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic               r_dx_neg, r_dy_neg, w_dx_nxt, w_dy_nxt;
    logic               r_paddle_hit, w_paddle_hit_nxt;
    logic               w_dy_refl;

    logic [COORD_W-1:0]      w_step;
    logic signed [COORD_W:0] w_x_raw, w_y_raw;
    logic [COORD_W-1:0]      w_x_pos, w_y_pos;
    logic                    w_x_dir, w_y_dir;
    logic                    w_x_hit_lo, w_x_hit_hi, w_y_hit_lo, w_y_hit_hi;
    logic                    w_paddle_cond, w_paddle_ev;
    logic [COORD_W-1:0]      w_track;
    int                      w_track_i;
    logic                    w_unused;

    ball_axis u_axis_x (
        .i_pos     (r_x),
        .i_dir_neg (r_dx_neg),
        .i_step    (w_step),
        .i_lo      (ZERO),
        .i_hi      (X_MAX),
        .o_raw     (w_x_raw),
        .o_pos     (w_x_pos),
        .o_dir_neg (w_x_dir),
        .o_hit_lo  (w_x_hit_lo),
        .o_hit_hi  (w_x_hit_hi)
    );

    ball_axis u_axis_y (
        .i_pos     (r_y),
        .i_dir_neg (r_dy_neg),
        .i_step    (w_step),
        .i_lo      (ZERO),
        .i_hi      (Y_MAX),
        .o_raw     (w_y_raw),
        .o_pos     (w_y_pos),
        .o_dir_neg (w_y_dir),
        .o_hit_lo  (w_y_hit_lo),
        .o_hit_hi  (w_y_hit_hi)
    );

    assign w_unused = ^{w_x_raw, w_x_hit_lo, w_x_hit_hi};

    // Serve position: ball centred on the paddle, clamped to the playfield.
    always_comb begin
        w_track_i = int'(paddle_x) + PADDLE_W / 2 - BALL_SIZE / 2;
        if (w_track_i < 0) begin
            w_track_i = 0;
        end else if (w_track_i > SCREEN_W - BALL_SIZE) begin
            w_track_i = SCREEN_W - BALL_SIZE;
        end
        w_track = COORD_W'(w_track_i);
    end

    assign w_paddle_cond = !r_dy_neg
                        && (int'(r_y) + BALL_SIZE <= PADDLE_Y)
                        && (int'(w_y_raw) + BALL_SIZE >= PADDLE_Y)
                        && (int'(r_x) + BALL_SIZE > int'(paddle_x))
                        && (int'(r_x) < int'(paddle_x) + PADDLE_W);
    assign w_paddle_ev = (r_state == ST_MOVE) && tick && w_paddle_cond;

`ifdef BALL_SPEEDUP_EN
    logic [3:0] r_hits;

    always_ff @(posedge clock) begin
        if (reset || (r_state == ST_LOST)) begin
            r_hits <= 4'd0;
        end else if (w_paddle_ev && (r_hits != 4'hf)) begin
            r_hits <= r_hits + 4'd1;
        end
    end

    assign w_step = (r_hits >= 4'd8) ? COORD_W'(2 * STEP) : COORD_W'(STEP);
`else
    assign w_step = COORD_W'(STEP);
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_dx_nxt         = r_dx_neg;
        w_dy_nxt         = r_dy_neg;
        w_paddle_hit_nxt = 1'b0;
        w_dy_refl        = 1'b0;
        case (r_state)
            ST_SERVE: begin
                w_x_nxt = w_track;
                w_y_nxt = Y_REST;
                if (launch) begin
                    w_state_nxt = ST_MOVE;
                    w_dx_nxt    = 1'b0;
                    w_dy_nxt    = 1'b1;
                end
            end
            ST_MOVE: begin
                if (tick) begin
                    if (w_paddle_ev) begin
                        w_x_nxt          = w_x_pos;
                        w_dx_nxt         = w_x_dir;
                        w_y_nxt          = Y_REST;
                        w_dy_nxt         = 1'b1;
                        w_paddle_hit_nxt = 1'b1;
                        w_dy_refl        = 1'b1;
                    end else if (w_y_hit_hi) begin
                        // Missed the paddle: freeze where the ball was.
                        w_state_nxt = ST_LOST;
                    end else begin
                        w_x_nxt   = w_x_pos;
                        w_dx_nxt  = w_x_dir;
                        w_y_nxt   = w_y_pos;
                        w_dy_nxt  = w_y_dir;
                        w_dy_refl = w_y_hit_lo;
                    end
                end
                // A brick flip on top of a tick reflection would cancel it out.
                if (brick_hit && !w_dy_refl) begin
                    w_dy_nxt = ~w_dy_nxt;
                end
            end
            ST_LOST: begin
                w_state_nxt = ST_SERVE;
                w_dx_nxt    = 1'b0;
                w_dy_nxt    = 1'b1;
            end
            default: begin
                w_state_nxt = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_SERVE;
            r_x          <= '0;
            r_y          <= '0;
            r_dx_neg     <= 1'b0;
            r_dy_neg     <= 1'b1;
            r_paddle_hit <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_dx_neg     <= w_dx_nxt;
            r_dy_neg     <= w_dy_nxt;
            r_paddle_hit <= w_paddle_hit_nxt;
        end
    end

    assign ball_x      = r_x;
    assign ball_y      = r_y;
    assign ball_dx_neg = r_dx_neg;
    assign ball_dy_neg = r_dy_neg;
    assign in_play     = (r_state == ST_MOVE);
    assign paddle_hit  = r_paddle_hit;
    assign ball_lost   = (r_state == ST_LOST);

endmodule
